key_step_ctrl: RTL and testbench
================================

KEY_STEP_CTRL -- requirements
Module: key_step_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 500000: cycles KEY must stay high after the initial pulse before auto-repeat starts.
REQ-002 Parameter REPEAT_CYCLES, default 100000: cycles between auto-repeat pulses.
REQ-003 Parameter CNT_W, default 16: width of press_cnt.
REQ-004 CLK  input  1  system clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 KEY  input  1  debounced key level, already synchronous to CLK; 1 = pressed.
REQ-007 step_en  input  1  1 = pulses allowed; 0 = pulses and counting suppressed.
REQ-008 step_pulse  output  1  registered, one-CLK-wide step strobe for the CPU single-step clock.
REQ-009 key_held  output  1  registered; 1 while FSM is not in IDLE.
REQ-010 press_cnt  output  CNT_W  registered count of issued step_pulse strobes.

Function
REQ-011 FSM states SHALL be IDLE, PRESS and REPEAT, with REPEAT present only per REQ-024.
REQ-012 A registered copy key_d of KEY SHALL be kept; a rising edge is KEY=1 with key_d=0.
REQ-013 IDLE: on a rising edge, go to PRESS, clear the timer, and assert step_pulse in the next cycle (latency 1 CLK).
REQ-014 PRESS: KEY=0 -> IDLE, no pulse; otherwise timer increments by 1 each cycle.
REQ-015 PRESS: timer == HOLD_CYCLES-1 with KEY=1 -> REPEAT, clear timer, assert step_pulse next cycle.
REQ-016 REPEAT: KEY=0 -> IDLE; timer == REPEAT_CYCLES-1 with KEY=1 -> clear timer, assert step_pulse next cycle; otherwise timer increments.
REQ-017 Release and timer expiry in the same cycle: release wins; go to IDLE; no pulse.
REQ-018 step_pulse SHALL never be high for two consecutive cycles; it is gated by step_en sampled in the same cycle as the triggering condition.
REQ-019 step_en=0 SHALL suppress step_pulse and the press_cnt increment only; FSM transitions and timer behaviour are unchanged.
REQ-020 press_cnt SHALL increment by 1 in the cycle step_pulse is registered high, and wrap from all-ones to 0.
REQ-021 Timer width SHALL be sized for max(HOLD_CYCLES, REPEAT_CYCLES) and SHALL never wrap.

Reset
REQ-022 While Reset=1: state=IDLE, timer=0, step_pulse=0, key_held=0, press_cnt=0, key_d=1.
REQ-023 key_d resets to 1, so a key held through reset release produces no pulse until KEY goes 0 and then 1; reset mid-press aborts the press with no further pulses.

Configuration
REQ-024 Macro KEY_AUTOREPEAT_EN defined: REPEAT state and REQ-015/REQ-016 are implemented.
REQ-025 Macro KEY_AUTOREPEAT_EN undefined: REPEAT state, the HOLD/REPEAT compare logic and the timer are removed; PRESS holds until KEY=0, giving exactly one pulse per press; parameters HOLD_CYCLES and REPEAT_CYCLES are accepted but unused.

Verification (HOLD_CYCLES=20, REPEAT_CYCLES=5, macro defined unless noted)
REQ-026 Reset then KEY 0->1 held for 10 cycles then 0 -> step_pulse exactly once, 1 cycle after the edge; press_cnt=1; key_held high for 10 cycles.
REQ-027 KEY held for 40 cycles -> pulses at edge+1, edge+21, edge+26, edge+31, edge+36; press_cnt=5.
REQ-028 KEY released in the exact cycle the timer hits 19 -> no second pulse; state IDLE; press_cnt=1.
REQ-029 step_en=0 during a 40-cycle hold -> step_pulse stays 0 and press_cnt stays 0; key_held follows KEY.
REQ-030 KEY=1 while Reset is deasserted -> no pulse; after KEY goes 0 then 1 -> one pulse. With press_cnt preloaded to 0xFFFF via pulses, the next pulse -> press_cnt=0.
REQ-031 Macro undefined, KEY held for 100 cycles -> exactly one pulse; press_cnt=1.

Source files
------------

// File: rtl/key_step_ctrl.sv
// Key-driven single-step pulse generator: one strobe per key press, optional auto-repeat while held.
// Define KEY_AUTOREPEAT_EN to build the REPEAT state and hold/repeat timer; without it, one pulse per press.
module key_step_ctrl #(
  parameter int HOLD_CYCLES   = 500000,
  parameter int REPEAT_CYCLES = 100000,
  parameter int CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             KEY,
  input  logic             step_en,
  output logic             step_pulse,
  output logic             key_held,
  output logic [CNT_W-1:0] press_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRESS = 2'd1;
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [1:0] REPEAT = 2'd2;
  localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nxt;
`endif

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       key_d;
  logic       rise;
  logic       trig;
  logic       fire;

  assign rise = KEY & ~key_d;
  // Back-to-back triggers (e.g. HOLD_CYCLES=1) are thinned so the strobe is never two cycles wide.
  assign fire = trig & step_en & ~step_pulse;

  always_comb begin
    state_nxt = state;
    trig      = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    timer_nxt = timer;
`endif
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS;
          trig      = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
          timer_nxt = '0;
`endif
        end
      end
      PRESS: begin
        if (!KEY) begin
          state_nxt = IDLE;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (timer == HOLD_LAST) begin
          state_nxt = REPEAT;
          timer_nxt = '0;
          trig      = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
`endif
      end
`ifdef KEY_AUTOREPEAT_EN
      REPEAT: begin
        // Release is tested first so it beats a same-cycle expiry.
        if (!KEY) begin
          state_nxt = IDLE;
        end else if (timer == REP_LAST) begin
          timer_nxt = '0;
          trig      = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // key_d resets high so a key already down at reset release is not taken as a new press.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      key_d      <= 1'b1;
      step_pulse <= 1'b0;
      key_held   <= 1'b0;
      press_cnt  <= '0;
`ifdef KEY_AUTOREPEAT_EN
      timer      <= '0;
`endif
    end else begin
      state      <= state_nxt;
      key_d      <= KEY;
      step_pulse <= fire;
      key_held   <= (state_nxt != IDLE);
      if (fire) begin
        press_cnt <= press_cnt + 1'b1;
      end
`ifdef KEY_AUTOREPEAT_EN
      timer      <= timer_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_key_step_ctrl.sv
// Bench for key_step_ctrl: age-based reference model checked every cycle plus directed press scenarios.
// Follows KEY_AUTOREPEAT_EN the same way the design does.
module tb_key_step_ctrl;

  localparam int HOLD = 20;
  localparam int REP  = 5;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        KEY = 1'b0;
  logic        step_en = 1'b1;
  logic        step_pulse, key_held;
  logic [15:0] press_cnt;
  logic        step_pulse_w, key_held_w;
  logic [3:0]  press_cnt_w;

  always #5 CLK = ~CLK;

  key_step_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .KEY(KEY), .step_en(step_en),
    .step_pulse(step_pulse), .key_held(key_held), .press_cnt(press_cnt)
  );

  // Narrow counter copy so wrap-around is reachable in a short run.
  key_step_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(4)) dut_w (
    .CLK(CLK), .Reset(Reset), .KEY(KEY), .step_en(step_en),
    .step_pulse(step_pulse_w), .key_held(key_held_w), .press_cnt(press_cnt_w)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a press starts at a rising edge (age 0); pulses follow the cycles at age 0
  // and, with auto-repeat, at ages HOLD, HOLD+REP, HOLD+2*REP ... while the key stays down.
  bit m_in = 1'b0, m_prev = 1'b1, m_pulse = 1'b0, m_held = 1'b0;
  int m_age = 0;
  int m_cnt = 0;

  always @(posedge CLK or posedge Reset) begin
    bit trig;
    if (Reset) begin
      m_in = 1'b0; m_prev = 1'b1; m_pulse = 1'b0; m_held = 1'b0; m_age = 0; m_cnt = 0;
    end else begin
      trig = 1'b0;
      if (m_in) begin
        if (!KEY) m_in = 1'b0;
        else begin
          m_age++;
          if (AUTO && m_age >= HOLD && ((m_age - HOLD) % REP) == 0) trig = 1'b1;
        end
      end else if (KEY && !m_prev) begin
        m_in = 1'b1; m_age = 0; trig = 1'b1;
      end
      m_pulse = trig && step_en && !m_pulse;
      if (m_pulse) m_cnt++;
      m_held = m_in;
      m_prev = KEY;
    end
  end

  bit chk_en = 1'b0;
  always @(posedge CLK) begin
    #2;
    if (chk_en) begin
      check("cyc_pulse", step_pulse, m_pulse);
      check("cyc_held", key_held, m_held);
      check("cyc_cnt", press_cnt, m_cnt[15:0]);
      check("cyc_pulse_w", step_pulse_w, m_pulse);
      check("cyc_cnt_w", press_cnt_w, m_cnt[3:0]);
    end
  end

  int p_idx[$];
  int p_held;

  // Sample i is taken just after the i-th rising edge counted from the one that sees KEY rise.
  task automatic press(input int len, input int total);
    p_idx.delete();
    p_held = 0;
    for (int i = 0; i < total; i++) begin
      @(negedge CLK);
      KEY = (i < len);
      @(posedge CLK);
      #2;
      if (step_pulse) p_idx.push_back(i);
      if (key_held) p_held++;
    end
    @(negedge CLK);
    KEY = 1'b0;
  endtask

  function automatic int idx_at(input int k);
    return (k < p_idx.size()) ? p_idx[k] : -1;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_pulse", step_pulse, 0);
    check("rst_held", key_held, 0);
    check("rst_cnt", press_cnt, 0);
    chk_en = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;

    // Short press: one pulse right after the edge, held for exactly the key-down time.
    press(10, 14);
    check("r26_npulse", p_idx.size(), 1);
    check("r26_idx0", idx_at(0), 0);
    check("r26_held", p_held, 10);
    check("r26_cnt", press_cnt, 1);

    do_reset();
    press(40, 44);
    check("r27_npulse", p_idx.size(), AUTO ? 5 : 1);
    check("r27_idx0", idx_at(0), 0);
    check("r27_idx1", idx_at(1), AUTO ? 20 : -1);
    check("r27_idx4", idx_at(4), AUTO ? 35 : -1);
    check("r27_cnt", press_cnt, AUTO ? 5 : 1);
    check("r27_held", p_held, 40);

    // Release lands exactly on hold expiry: no second pulse.
    do_reset();
    press(20, 24);
    check("r28_npulse", p_idx.size(), 1);
    check("r28_held", key_held, 0);
    check("r28_cnt", press_cnt, 1);

    // One cycle longer: the hold pulse just makes it.
    do_reset();
    press(21, 25);
    check("hold_edge_npulse", p_idx.size(), AUTO ? 2 : 1);
    check("hold_edge_idx1", idx_at(1), AUTO ? 20 : -1);

    do_reset();
    @(negedge CLK);
    step_en = 1'b0;
    press(40, 44);
    check("r29_npulse", p_idx.size(), 0);
    check("r29_cnt", press_cnt, 0);
    check("r29_held", p_held, 40);
    step_en = 1'b1;

    // Key already down when reset releases.
    @(negedge CLK);
    KEY = 1'b1;
    Reset = 1'b1;
    repeat (2) @(negedge CLK);
    Reset = 1'b0;
    press(5, 5);
    check("r30_stuck_npulse", p_idx.size(), 0);
    check("r30_stuck_held", p_held, 0);
    press(3, 6);
    check("r30_repress_npulse", p_idx.size(), 1);
    check("r30_repress_cnt", press_cnt, 1);

    // Reset in the middle of a held press aborts it.
    do_reset();
    @(negedge CLK);
    KEY = 1'b1;
    repeat (3) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    press(30, 30);
    check("midrst_npulse", p_idx.size(), 0);
    check("midrst_cnt", press_cnt, 0);

    // Counter wrap on the 4-bit copy.
    do_reset();
    for (int k = 0; k < 15; k++) press(1, 2);
    check("wrap_pre_w", press_cnt_w, 15);
    press(1, 2);
    check("wrap_post_w", press_cnt_w, 0);
    check("wrap_post", press_cnt, 16);

    do_reset();
    press(100, 104);
    check("r31_npulse", p_idx.size(), AUTO ? 17 : 1);
    check("r31_cnt", press_cnt, AUTO ? 17 : 1);

    // Asynchronous reset asserted between clock edges while a pulse is high.
    do_reset();
    @(negedge CLK);
    KEY = 1'b1;
    @(posedge CLK);
    #3;
    check("async_pre_pulse", step_pulse, 1);
    Reset = 1'b1;
    #1;
    check("async_pulse", step_pulse, 0);
    check("async_held", key_held, 0);
    check("async_cnt", press_cnt, 0);
    @(negedge CLK);
    KEY = 1'b0;
    Reset = 1'b0;
    repeat (3) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
